// File: rtl/tx_ram_pkg.sv
// Shared types and helpers for the ping-pong TX frame store.
package tx_ram_pkg;

  typedef logic       bank_sel_t;
  typedef logic [1:0] full_cnt_t;

  localparam full_cnt_t FULL_NONE = 2'd0;
  localparam full_cnt_t FULL_BOTH = 2'd2;

  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] total);
    return (addr < total);
  endfunction

endpackage

// File: rtl/tx_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one enable-gated registered read port.
module tx_sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port; contents are never cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read, held when not enabled so the output word stays stable under back-pressure.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= {DATA_WIDTH{1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tx_frame_pingpong_ram.sv
// Two-bank TX frame store: producer fills the write bank while the read bank streams out
// over valid/ready; banks hand over on commit and return on acceptance of the last word.
module tx_frame_pingpong_ram
  import tx_ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_PIXELS  = 9600,
  parameter int ADDR_WIDTH    = $clog2(TOTAL_PIXELS),
  parameter int START_ON_TICK = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic                  frame_tick,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  addr_err
);

  // Read counter has one extra bit so "all words issued" is distinguishable from index 0.
  localparam logic [ADDR_WIDTH:0] RD_END   = (ADDR_WIDTH+1)'(TOTAL_PIXELS);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(TOTAL_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0] RD_ONE   = (ADDR_WIDTH+1)'(1);

  bank_sel_t           r_wb;
  bank_sel_t           r_rb;
  full_cnt_t           r_full_cnt;
  logic [ADDR_WIDTH:0] r_rd_cnt;
  logic                r_armed;
  logic                r_m_valid;
  logic                r_m_last;
  logic                r_frame_done;
  logic                r_overflow;
  logic                r_addr_err;

  logic                w_in_range;
  logic                w_wr_ready;
  logic                w_wr_ok;
  logic                w_commit_ok;
  logic                w_accept;
  logic                w_last_accept;
  logic                w_armed;
  logic                w_rd_issue;
  logic [ADDR_WIDTH:0] w_ram_wr_addr;
  logic [ADDR_WIDTH:0] w_ram_rd_addr;

  // Handshake qualifiers derived from registered state.
  always_comb begin
    w_in_range    = addr_in_range(32'(wr_addr), 32'(TOTAL_PIXELS));
    w_wr_ready    = (r_full_cnt != FULL_BOTH);
    w_wr_ok       = wr_en & w_wr_ready & w_in_range;
    w_commit_ok   = wr_commit & w_wr_ready;
    w_accept      = r_m_valid & m_ready;
    w_last_accept = w_accept & r_m_last;
    if (START_ON_TICK != 0) begin
      w_armed = r_armed;
    end else begin
      w_armed = (r_full_cnt != FULL_NONE);
    end
    w_rd_issue    = w_armed & (r_full_cnt != FULL_NONE) & (r_rd_cnt != RD_END)
                    & (~r_m_valid | m_ready);
    w_ram_wr_addr = {r_wb, wr_addr};
    w_ram_rd_addr = {r_rb, r_rd_cnt[ADDR_WIDTH-1:0]};
  end

  // Bank ownership, fill count and stream control.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb         <= 1'b0;
      r_rb         <= 1'b0;
      r_full_cnt   <= FULL_NONE;
      r_rd_cnt     <= {(ADDR_WIDTH+1){1'b0}};
      r_armed      <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      if (w_commit_ok) begin
        r_wb <= ~r_wb;
      end
      if (w_last_accept) begin
        r_rb <= ~r_rb;
      end

      // Commit and last-accept in the same cycle cancel out.
      case ({w_commit_ok, w_last_accept})
        2'b10:   r_full_cnt <= r_full_cnt + 2'd1;
        2'b01:   r_full_cnt <= r_full_cnt - 2'd1;
        default: r_full_cnt <= r_full_cnt;
      endcase

      if (w_last_accept) begin
        r_rd_cnt <= {(ADDR_WIDTH+1){1'b0}};
      end else if (w_rd_issue) begin
        r_rd_cnt <= r_rd_cnt + RD_ONE;
      end

      if (w_last_accept) begin
        r_armed <= 1'b0;
      end else if (frame_tick && (r_full_cnt != FULL_NONE)) begin
        r_armed <= 1'b1;
      end

      if (w_rd_issue) begin
        r_m_valid <= 1'b1;
        r_m_last  <= (r_rd_cnt == LAST_IDX);
      end else if (w_accept) begin
        r_m_valid <= 1'b0;
      end

      r_frame_done <= w_last_accept;

      if ((wr_en | wr_commit) & ~w_wr_ready) begin
        r_overflow <= 1'b1;
      end
      if (wr_en & ~w_in_range) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  tx_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH + 1)
  ) u_ram (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (w_ram_wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (w_ram_rd_addr),
    .o_rd_data (m_data)
  );

  assign wr_ready   = w_wr_ready;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_tx_frame_pingpong_ram.sv
// Scoreboard bench for tx_frame_pingpong_ram with a 16-pixel frame; one tick-gated and one free-running instance.
module tb_tx_frame_pingpong_ram;

  localparam int DW = 8;
  localparam int TP = 16;
  localparam int AW = 5;
  localparam int AW0 = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_commit = 1'b0;
  logic          wr_ready;
  logic          frame_tick = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          frame_done;
  logic          overflow;
  logic          addr_err;

  logic           d0_wr_en = 1'b0;
  logic [AW0-1:0] d0_wr_addr = '0;
  logic [DW-1:0]  d0_wr_data = '0;
  logic           d0_wr_commit = 1'b0;
  logic           d0_wr_ready;
  logic           d0_m_valid;
  logic [DW-1:0]  d0_m_data;
  logic           d0_m_last;
  logic           d0_m_ready = 1'b0;
  logic           d0_frame_done;
  logic           d0_overflow;
  logic           d0_addr_err;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  tx_frame_pingpong_ram #(
    .DATA_WIDTH(DW), .TOTAL_PIXELS(TP), .ADDR_WIDTH(AW), .START_ON_TICK(1)
  ) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_ready(wr_ready), .frame_tick(frame_tick),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .frame_done(frame_done), .overflow(overflow), .addr_err(addr_err)
  );

  tx_frame_pingpong_ram #(
    .DATA_WIDTH(DW), .TOTAL_PIXELS(TP), .START_ON_TICK(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(d0_wr_en), .wr_addr(d0_wr_addr), .wr_data(d0_wr_data),
    .wr_commit(d0_wr_commit), .wr_ready(d0_wr_ready), .frame_tick(1'b0),
    .m_valid(d0_m_valid), .m_data(d0_m_data), .m_last(d0_m_last), .m_ready(d0_m_ready),
    .frame_done(d0_frame_done), .overflow(d0_overflow), .addr_err(d0_addr_err)
  );

  task automatic write_frame(input logic [DW-1:0] base);
    exp_t e;
    for (int i = 0; i < TP; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = base + DW'(i);
      e.data  = base + DW'(i);
      e.last  = (i == TP - 1);
      sb_q.push_back(e);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    @(negedge clk);
    wr_commit = 1'b1;
    @(negedge clk);
    wr_commit = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Consumer side of the scoreboard: drives m_ready, pops on each accept, checks hold stability.
  task automatic run_consumer(input int n_pops, input int mode, input bit commit_on_last,
                              output int frames, output int bubbles, output int ready_drops);
    int            pops = 0;
    int            cyc = 0;
    bit            hold = 1'b0;
    bit            seen = 1'b0;
    logic [DW-1:0] hd = '0;
    logic          hl = 1'b0;
    exp_t          e;
    frames = 0;
    bubbles = 0;
    ready_drops = 0;
    while (pops < n_pops && cyc < 400) begin
      @(negedge clk);
      cyc++;
      wr_commit = 1'b0;
      if (frame_done) frames++;
      if (!wr_ready) ready_drops++;
      if (seen && !m_valid) bubbles++;
      if (m_valid) seen = 1'b1;
      if (hold) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== hd || m_last !== hl) begin
          miscompares++;
          $display("FAIL hold_stable: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                   m_valid, m_data, m_last, hd, hl);
        end
      end
      m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 1) || (cyc % 4 == 0));
      hold = m_valid && !m_ready;
      hd = m_data;
      hl = m_last;
      if (m_valid && m_ready) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL stream_extra: got data=%h with empty scoreboard, want no word", m_data);
        end else begin
          e = sb_q.pop_front();
          if (m_data !== e.data || m_last !== e.last) begin
            miscompares++;
            $display("FAIL stream_word: got data=%h last=%b, want data=%h last=%b",
                     m_data, m_last, e.data, e.last);
          end
          pops++;
          if (commit_on_last && e.last) wr_commit = 1'b1;
        end
      end
    end
    if (pops < n_pops) begin
      vectors++;
      miscompares++;
      $display("FAIL stream_timeout: got %0d words, want %0d", pops, n_pops);
    end
    @(negedge clk);
    wr_commit = 1'b0;
    if (frame_done) frames++;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({m_valid, m_last, m_data, frame_done, overflow, addr_err, wr_ready} !==
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b l=%b d=%h fd=%b ov=%b ae=%b rdy=%b, want 0 0 00 0 0 0 1",
               m_valid, m_last, m_data, frame_done, overflow, addr_err, wr_ready);
    end
    vectors++;
    if ({d0_m_valid, d0_wr_ready, d0_overflow, d0_addr_err} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_state_d0: got v=%b rdy=%b ov=%b ae=%b, want 0 1 0 0",
               d0_m_valid, d0_wr_ready, d0_overflow, d0_addr_err);
    end
  endtask

  task automatic test_basic();
    int f, b, r;
    write_frame(8'h10);
    pulse_commit();
    pulse_tick();
    run_consumer(TP, 0, 1'b0, f, b, r);
    vectors++;
    if (f !== 1) begin miscompares++; $display("FAIL basic_frame_done: got %0d pulses, want 1", f); end
    vectors++;
    if (b !== 0) begin miscompares++; $display("FAIL basic_bubbles: got %0d, want 0", b); end
    vectors++;
    if (r !== 0) begin miscompares++; $display("FAIL basic_wr_ready: got %0d low cycles, want 0", r); end
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL basic_idle: got m_valid=%b, want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    int f, b, r;
    write_frame(8'h50);
    pulse_commit();
    pulse_tick();
    run_consumer(TP, 1, 1'b0, f, b, r);
    vectors++;
    if (f !== 1) begin miscompares++; $display("FAIL bp_frame_done: got %0d pulses, want 1", f); end
    vectors++;
    if (sb_q.size() !== 0) begin miscompares++; $display("FAIL bp_leftover: got %0d, want 0", sb_q.size()); end
  endtask

  task automatic test_pingpong();
    int f, b, r;
    write_frame(8'hA0);
    pulse_commit();
    write_frame(8'hB0);
    pulse_commit();
    vectors++;
    if ({wr_ready, overflow} !== 2'b00) begin
      miscompares++;
      $display("FAIL pp_full: got wr_ready=%b overflow=%b, want 0 0", wr_ready, overflow);
    end
    pulse_commit();
    vectors++;
    if ({wr_ready, overflow} !== 2'b01) begin
      miscompares++;
      $display("FAIL pp_overflow: got wr_ready=%b overflow=%b, want 0 1", wr_ready, overflow);
    end
    pulse_tick();
    run_consumer(TP, 0, 1'b0, f, b, r);
    vectors++;
    if (f !== 1 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pp_first: got frames=%0d wr_ready=%b, want 1 1", f, wr_ready);
    end
    pulse_tick();
    run_consumer(TP, 0, 1'b0, f, b, r);
    vectors++;
    if (f !== 1) begin miscompares++; $display("FAIL pp_second: got frames=%0d, want 1", f); end
  endtask

  task automatic test_simultaneous();
    int f, b, r;
    write_frame(8'hC0);
    pulse_commit();
    write_frame(8'hD0);
    pulse_tick();
    run_consumer(TP, 0, 1'b1, f, b, r);
    repeat (3) @(negedge clk);
    vectors++;
    if ({wr_ready, m_valid} !== 2'b10 || f !== 1) begin
      miscompares++;
      $display("FAIL simul_count: got wr_ready=%b m_valid=%b frames=%0d, want 1 0 1", wr_ready, m_valid, f);
    end
    pulse_tick();
    run_consumer(TP, 0, 1'b0, f, b, r);
    vectors++;
    if (f !== 1 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_second: got frames=%0d wr_ready=%b, want 1 1", f, wr_ready);
    end
  endtask

  task automatic test_gating();
    int f, b, r;
    int seen_valid = 0;
    pulse_tick();
    write_frame(8'hE0);
    pulse_commit();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_valid) seen_valid++;
    end
    vectors++;
    if (seen_valid !== 0) begin
      miscompares++;
      $display("FAIL gate_no_tick: got m_valid high %0d cycles, want 0", seen_valid);
    end
    pulse_tick();
    run_consumer(TP, 0, 1'b0, f, b, r);
    vectors++;
    if (f !== 1) begin miscompares++; $display("FAIL gate_stream: got frames=%0d, want 1", f); end
  endtask

  task automatic test_errors();
    int f, b, r;
    write_frame(8'h20);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'd16;
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    vectors++;
    if (addr_err !== 1'b1) begin miscompares++; $display("FAIL addr_err_flag: got %b, want 1", addr_err); end
    pulse_commit();
    pulse_tick();
    run_consumer(TP, 0, 1'b0, f, b, r);
    vectors++;
    if (f !== 1) begin miscompares++; $display("FAIL addr_err_stream: got frames=%0d, want 1", f); end
  endtask

  task automatic test_reset_midstream();
    int f, b, r;
    int seen_valid = 0;
    write_frame(8'h60);
    pulse_commit();
    pulse_tick();
    run_consumer(7, 0, 1'b0, f, b, r);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({m_valid, m_last, m_data, frame_done, overflow, addr_err, wr_ready} !==
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset_state: got v=%b l=%b d=%h fd=%b ov=%b ae=%b rdy=%b, want 0 0 00 0 0 0 1",
               m_valid, m_last, m_data, frame_done, overflow, addr_err, wr_ready);
    end
    sb_q.delete();
    pulse_tick();
    repeat (5) begin
      @(negedge clk);
      if (m_valid) seen_valid++;
    end
    vectors++;
    if (seen_valid !== 0) begin
      miscompares++;
      $display("FAIL midreset_discard: got m_valid high %0d cycles, want 0", seen_valid);
    end
    write_frame(8'h70);
    pulse_commit();
    pulse_tick();
    run_consumer(TP, 0, 1'b0, f, b, r);
    vectors++;
    if (f !== 1) begin miscompares++; $display("FAIL midreset_recover: got frames=%0d, want 1", f); end
  endtask

  task automatic test_no_tick();
    exp_t e;
    int   pops = 0;
    int   cyc = 0;
    for (int i = 0; i < TP; i++) begin
      @(negedge clk);
      d0_wr_en   = 1'b1;
      d0_wr_addr = AW0'(i);
      d0_wr_data = 8'h80 + DW'(i);
      e.data     = 8'h80 + DW'(i);
      e.last     = (i == TP - 1);
      sb_q.push_back(e);
    end
    @(negedge clk);
    d0_wr_en = 1'b0;
    d0_wr_commit = 1'b1;
    @(negedge clk);
    d0_wr_commit = 1'b0;
    vectors++;
    if (d0_m_valid !== 1'b0) begin miscompares++; $display("FAIL notick_early: got m_valid=%b, want 0", d0_m_valid); end
    @(negedge clk);
    vectors++;
    if (d0_m_valid !== 1'b1) begin miscompares++; $display("FAIL notick_rise: got m_valid=%b, want 1", d0_m_valid); end
    d0_m_ready = 1'b1;
    while (pops < TP && cyc < 40) begin
      if (d0_m_valid) begin
        e = sb_q.pop_front();
        vectors++;
        if (d0_m_data !== e.data || d0_m_last !== e.last) begin
          miscompares++;
          $display("FAIL notick_word: got data=%h last=%b, want data=%h last=%b",
                   d0_m_data, d0_m_last, e.data, e.last);
        end
        pops++;
      end
      @(negedge clk);
      cyc++;
    end
    d0_m_ready = 1'b0;
    vectors++;
    if (pops !== TP || d0_frame_done !== 1'b1 || d0_m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL notick_end: got pops=%0d frame_done=%b m_valid=%b, want %0d 1 0",
               pops, d0_frame_done, d0_m_valid, TP);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_pingpong();
    test_simultaneous();
    test_gating();
    test_errors();
    test_reset_midstream();
    test_no_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_frame_pingpong_ram.md
Name: tx_frame_pingpong_ram

Overview:
- Double-buffered (ping-pong) transmit frame store between the pixel producer and the UART/TX serializer.
- The producer fills one bank while the other bank streams out over a valid/ready interface.
- Banks swap on explicit frame commit. Optionally, streaming is gated by frame_tick.
- Parametrised successor to the single-bank TX frame RAM: adds back-pressure, two banks, overflow/error flags and a last-pixel marker.

Parameters:
- DATA_WIDTH, 8, pixel word width.
- TOTAL_PIXELS, 9600, words per frame (per bank).
- ADDR_WIDTH, $clog2(TOTAL_PIXELS), pixel address width.
- START_ON_TICK, 1, 1 = a full bank starts streaming only after frame_tick; 0 = starts as soon as it is full.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  pixel write strobe (write bank).
- wr_addr  in  ADDR_WIDTH  pixel address within write bank.
- wr_data  in  DATA_WIDTH  pixel data.
- wr_commit  in  1  one-cycle pulse: write bank complete, hand to reader.
- wr_ready  out  1  write bank is free (full_cnt < 2).
- frame_tick  in  1  start request for streaming (START_ON_TICK=1).
- m_valid  out  1  output word valid.
- m_data  out  DATA_WIDTH  output pixel.
- m_last  out  1  m_data is pixel TOTAL_PIXELS-1.
- m_ready  in  1  consumer accepts when m_valid & m_ready.
- frame_done  out  1  one-cycle pulse after last pixel accepted.
- overflow  out  1  sticky: write or commit attempted with wr_ready=0.
- addr_err  out  1  sticky: wr_en with wr_addr >= TOTAL_PIXELS.

Behaviour:
- Reset values:
  - wb=0, rb=0, full_cnt=0, rd_cnt=0, armed=0.
  - Outputs: m_valid=0, m_last=0, m_data=0, frame_done=0, overflow=0, addr_err=0, wr_ready=1.
  - Reset mid-stream discards both banks' status. Memory contents are not cleared.
- Write:
  - When wr_en & wr_ready & wr_addr < TOTAL_PIXELS, mem[wb][wr_addr] <= wr_data.
  - Otherwise the write is dropped and the matching sticky flag is set.
- Commit:
  - When wr_commit & wr_ready: wb toggles and full_cnt increments.
  - When wr_commit & !wr_ready: ignored, overflow set.
  - A commit with no preceding writes is legal.
- Arming:
  - armed is set by frame_tick while full_cnt>0 (START_ON_TICK=1), or is always 1 when full_cnt>0 (START_ON_TICK=0).
  - frame_tick with full_cnt=0 is ignored, not remembered.
- Read pipeline:
  - rd_issue = armed & full_cnt>0 & rd_cnt not yet exhausted & (!m_valid | m_ready).
  - On rd_issue, m_data <= mem[rb][rd_cnt] (1-cycle synchronous read, enable-gated), m_valid <= 1, m_last <= (rd_cnt==TOTAL_PIXELS-1), rd_cnt++.
  - m_data, m_valid and m_last hold while m_valid & !m_ready.
  - On accept with no new issue, m_valid <= 0.
  - Zero-bubble streaming when m_ready is held high.
- End of frame:
  - On acceptance of the m_last word: frame_done pulses the next cycle, rb toggles, full_cnt decrements, rd_cnt <= 0, armed cleared (START_ON_TICK=1).
- Simultaneous commit and last-accept: full_cnt unchanged; both wb and rb toggle.
- Write to wb while rb streams never aliases, because wb != rb whenever full_cnt=1 and streaming.
- wr_ready = (full_cnt != 2), combinational from the registered count.

Decomposition:
- Package tx_ram_pkg holds:
  - typedef bank_sel_t (1 bit).
  - typedef full_cnt_t (2 bits).
  - function addr_in_range().
- Sub-module tx_sdp_ram:
  - Simple dual-port synchronous RAM, depth 2*TOTAL_PIXELS, address {bank, pixel}.
  - Write port plus enable-gated registered read port.
  - Infers BRAM.

Test Plan (TOTAL_PIXELS=16 in simulation):
- Basic stream: write 0..15 with data=addr+0x10, commit, frame_tick, m_ready=1 -> m_data 0x10..0x1F on 16 consecutive cycles, m_last only on 0x1F, frame_done one pulse, wr_ready stays 1.
- Back-pressure: same frame, m_ready toggled 1,0,0,1 pattern -> no word lost or duplicated, m_data stable while m_valid & !m_ready.
- Ping-pong: fill A=0xA0.., commit, fill B=0xB0.., commit -> wr_ready=0; a third commit sets overflow=1; streaming yields A then B (two frame_tick pulses).
- Simultaneous: commit B on the exact cycle A's last word is accepted -> full_cnt stays 1, next frame streams B correctly.
- Gating: START_ON_TICK=1, commit without frame_tick -> m_valid stays 0 for 100 cycles. Tick before commit -> ignored. START_ON_TICK=0 -> m_valid rises 1 cycle after commit.
- Errors/reset: wr_en with wr_addr=16 -> addr_err=1, memory unchanged. Reset at pixel 7 of a stream -> m_valid=0, wr_ready=1, flags 0 the next cycle.
